// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Decodes single-byte host commands from the UART receive path, applies
//   them to a 6-bit LED register and paces a 1-3 byte reply onto the UART
//   transmit path, one byte every TX_GAP_CYCLES clocks.
//
// Ports
//   clk_50m       : board clock, all logic on its rising edge
//   reset_n       : synchronous active-low reset
//   rx_data[7:0]  : received byte, captured on the rising edge of rx_done
//   rx_done       : byte-received strobe (any width, rising edge used)
//   timer_second  : seconds count, sampled by the read-seconds command
//   tx_data[7:0]  : reply byte, stable between tx_enable pulses
//   tx_enable     : one-cycle transmit start pulse
//   led[5:0]      : LED register
//   cmd_overrun   : one-cycle pulse when a command arrives while busy
module uart_cmd_responder #(
  parameter int unsigned TX_GAP_CYCLES = 4800
) (
  input  logic        clk_50m,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic [15:0] timer_second,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  output logic [5:0]  led,
  output logic        cmd_overrun
);

  // GAP holds TX_GAP_CYCLES-1 clocks; together with the SEND cycle this
  // spaces tx_enable rising edges exactly TX_GAP_CYCLES apart.
  localparam int unsigned CW = (TX_GAP_CYCLES > 2) ? $clog2(TX_GAP_CYCLES - 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(TX_GAP_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SEND,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic            rx_hist_q, rx_hist_d;
  logic            edge_q, edge_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [5:0]      led_q, led_d;
  logic [2:0][7:0] rbuf_q, rbuf_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic            ovr_q, ovr_d;

  logic [7:0]      r0, r1, r2;
  logic [1:0]      rlen;
  logic            rx_rise;

  assign rx_rise = rx_done & ~rx_hist_q;

  always_comb begin
    state_d   = state_q;
    rx_hist_d = rx_done;
    edge_d    = rx_rise;
    cmd_d     = rx_rise ? rx_data : cmd_q;
    led_d     = led_q;
    rbuf_d    = rbuf_q;
    len_d     = len_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    ovr_d     = 1'b0;
    r0        = 8'hEE;
    r1        = cmd_q;
    r2        = 8'h00;
    rlen      = 2'd2;

    // Reply contents for the latched command (used only in DECODE).
    if (cmd_q <= 8'd5) begin
      r0   = 8'h80 | cmd_q;
      rlen = 2'd1;
    end else begin
      case (cmd_q)
        8'h10: begin
          r0   = 8'h90;
          r1   = {2'b00, led_q};
          rlen = 2'd2;
        end
        8'h11: begin
          r0   = 8'h91;
          r1   = timer_second[15:8];
          r2   = timer_second[7:0];
          rlen = 2'd3;
        end
        8'h20: begin
          r0   = 8'hA0;
          rlen = 2'd1;
        end
        default: begin
          r0   = 8'hEE;
          r1   = cmd_q;
          rlen = 2'd2;
        end
      endcase
    end

    // Any edge arriving while busy is dropped and flagged.
    if (edge_q && state_q != IDLE) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (edge_q) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cmd_q <= 8'd5) begin
          led_d = led_q ^ (6'(1) << cmd_q[2:0]);
        end else if (cmd_q == 8'h20) begin
          led_d = '0;
        end
        rbuf_d = {r2, r1, r0};
        len_d  = rlen;
        idx_d  = 2'd0;
        // Outputs are registered, so the first byte is launched on the
        // same edge that enters SEND.
        tx_data_d = r0;
        tx_en_d   = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) begin
          if ((idx_q + 2'd1) < len_q) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = rbuf_q[idx_q + 2'd1];
            tx_en_d   = 1'b1;
            state_d   = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rx_hist_q <= 1'b1;
      edge_q    <= 1'b0;
      cmd_q     <= '0;
      led_q     <= '0;
      rbuf_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_hist_q <= rx_hist_d;
      edge_q    <= edge_d;
      cmd_q     <= cmd_d;
      led_q     <= led_d;
      rbuf_q    <= rbuf_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_enable   = tx_en_q;
  assign led         = led_q;
  assign cmd_overrun = ovr_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  localparam int unsigned GAP = 16;

  logic        clk_50m = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [15:0] timer_second;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic [5:0]  led;
  logic        cmd_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pulse_data[$];
  int         pulse_cyc[$];
  int         ovr_cnt = 0;
  int         consec_err = 0;
  int         txd_err = 0;
  logic       prev_en = 1'b0;
  logic [7:0] prev_txd = 8'h00;
  logic       rst_at_edge;

  uart_cmd_responder #(.TX_GAP_CYCLES(GAP)) dut (
    .clk_50m      (clk_50m),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .timer_second (timer_second),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable),
    .led          (led),
    .cmd_overrun  (cmd_overrun)
  );

  always #5 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  // Records every transmit pulse and overrun pulse, and watches pulse rules.
  always @(posedge clk_50m) begin
    rst_at_edge = reset_n;
    #1;
    if (tx_enable) begin
      pulse_data.push_back(tx_data);
      pulse_cyc.push_back(cyc);
    end
    if (cmd_overrun) ovr_cnt++;
    if (tx_enable && prev_en) consec_err++;
    if (tx_data !== prev_txd && !tx_enable && rst_at_edge) txd_err++;
    prev_en  = tx_enable;
    prev_txd = tx_data;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  // Presents byte b, starting a rising edge that is sampled on edge e.
  task automatic send(input logic [7:0] b, input int w, output int e);
    rx_data = b;
    rx_done = 1'b1;
    e = cyc + 1;
    wait_cyc(e + w - 1);
    rx_done = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] b, input int n, output int e);
    send(b, 1, e);
    wait_cyc(e + 2 + n * GAP);
  endtask

  task automatic clear_log();
    pulse_data.delete();
    pulse_cyc.delete();
    ovr_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h05;
    timer_second = 16'h0000;
    repeat (3) @(posedge clk_50m);
    #1;
    checks++;
    if (led !== 6'd0 || tx_enable !== 1'b0 || tx_data !== 8'h00 || cmd_overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_values led=%b en=%b data=%h ovr=%b expected 0/0/00/0", led, tx_enable, tx_data, cmd_overrun);
    end
    clear_log();
    reset_n = 1'b1;
    wait_cyc(cyc + 10);
    checks++;
    if (pulse_data.size() !== 0 || led !== 6'd0 || ovr_cnt !== 0) begin
      failures++;
      $display("FAIL reset_held_strobe pulses=%0d led=%b ovr=%0d expected 0/000000/0", pulse_data.size(), led, ovr_cnt);
    end
    rx_done = 1'b0;
    wait_cyc(cyc + 2);
  endtask

  task automatic test_toggle();
    int e;
    clear_log();
    send(8'h03, 3, e);
    wait_cyc(e + 2);
    checks++;
    if (led !== 6'b001000 || tx_enable !== 1'b1 || tx_data !== 8'h83) begin
      failures++;
      $display("FAIL toggle3_first led=%b en=%b data=%h expected 001000/1/83", led, tx_enable, tx_data);
    end
    wait_cyc(e + 2 + GAP);
    checks++;
    if (pulse_data.size() !== 1 || pulse_cyc[0] !== e + 2) begin
      failures++;
      $display("FAIL toggle3_pulses count=%0d cyc=%0d expected 1 at %0d", pulse_data.size(), pulse_cyc[0], e + 2);
    end
    clear_log();
    run_cmd(8'h03, 1, e);
    checks++;
    if (led !== 6'b000000 || pulse_data.size() !== 1 || pulse_data[0] !== 8'h83) begin
      failures++;
      $display("FAIL toggle3_second led=%b count=%0d data=%h expected 000000/1/83", led, pulse_data.size(), pulse_data[0]);
    end
  endtask

  task automatic test_read_leds();
    int e;
    logic [7:0] exp_b[2];
    exp_b[0] = 8'h90;
    exp_b[1] = 8'h21;
    clear_log();
    run_cmd(8'h00, 1, e);
    run_cmd(8'h05, 1, e);
    checks++;
    if (led !== 6'b100001 || pulse_data.size() !== 2 || pulse_data[0] !== 8'h80 || pulse_data[1] !== 8'h85) begin
      failures++;
      $display("FAIL toggle0_5 led=%b count=%0d expected 100001/2 (80,85)", led, pulse_data.size());
    end
    clear_log();
    run_cmd(8'h10, 2, e);
    checks++;
    if (pulse_data.size() !== 2) begin
      failures++;
      $display("FAIL read_leds_count got=%0d expected 2", pulse_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (pulse_data[i] !== exp_b[i] || pulse_cyc[i] !== e + 2 + i * GAP) begin
          failures++;
          $display("FAIL read_leds_byte%0d got=%h@%0d expected %h@%0d", i, pulse_data[i], pulse_cyc[i], exp_b[i], e + 2 + i * GAP);
        end
      end
    end
    checks++;
    if (led !== 6'b100001) begin
      failures++;
      $display("FAIL read_leds_unchanged led=%b expected 100001", led);
    end
    clear_log();
    run_cmd(8'h20, 1, e);
    checks++;
    if (led !== 6'd0 || pulse_data.size() !== 1 || pulse_data[0] !== 8'hA0) begin
      failures++;
      $display("FAIL clear_leds led=%b count=%0d data=%h expected 000000/1/a0", led, pulse_data.size(), pulse_data[0]);
    end
  endtask

  task automatic test_seconds();
    int e;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h91;
    exp_b[1] = 8'h12;
    exp_b[2] = 8'h34;
    clear_log();
    timer_second = 16'h1234;
    send(8'h11, 1, e);
    wait_cyc(e + 2);
    timer_second = 16'h1235;
    wait_cyc(e + 10);
    checks++;
    if (tx_data !== 8'h91 || tx_enable !== 1'b0) begin
      failures++;
      $display("FAIL seconds_hold data=%h en=%b expected 91/0", tx_data, tx_enable);
    end
    wait_cyc(e + 2 + 3 * GAP);
    checks++;
    if (pulse_data.size() !== 3) begin
      failures++;
      $display("FAIL seconds_count got=%0d expected 3", pulse_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pulse_data[i] !== exp_b[i] || pulse_cyc[i] !== e + 2 + i * GAP) begin
          failures++;
          $display("FAIL seconds_byte%0d got=%h@%0d expected %h@%0d", i, pulse_data[i], pulse_cyc[i], exp_b[i], e + 2 + i * GAP);
        end
      end
    end
  endtask

  task automatic test_nak_overrun();
    int e;
    int e2;
    run_cmd(8'h04, 1, e);
    clear_log();
    send(8'h7F, 1, e);
    wait_cyc(e + 10);
    send(8'h02, 1, e2);
    wait_cyc(e + 2 + 2 * GAP + 4);
    checks++;
    if (pulse_data.size() !== 2 || pulse_data[0] !== 8'hEE || pulse_data[1] !== 8'h7F ||
        pulse_cyc[0] !== e + 2 || pulse_cyc[1] !== e + 2 + GAP) begin
      failures++;
      $display("FAIL nak_reply count=%0d expected 2 bytes ee,7f at %0d,%0d", pulse_data.size(), e + 2, e + 2 + GAP);
    end
    checks++;
    if (ovr_cnt !== 1) begin
      failures++;
      $display("FAIL overrun_pulse got=%0d expected 1", ovr_cnt);
    end
    checks++;
    if (led !== 6'b010000) begin
      failures++;
      $display("FAIL overrun_led led=%b expected 010000", led);
    end
    run_cmd(8'h04, 1, e);
  endtask

  task automatic test_reset_mid_reply();
    int e;
    run_cmd(8'h02, 1, e);
    clear_log();
    send(8'h11, 1, e);
    wait_cyc(e + 5);
    reset_n = 1'b0;
    wait_cyc(e + 6);
    reset_n = 1'b1;
    checks++;
    if (led !== 6'd0 || tx_data !== 8'h00 || tx_enable !== 1'b0 || cmd_overrun !== 1'b0) begin
      failures++;
      $display("FAIL midreset_values led=%b data=%h en=%b ovr=%b expected 0/00/0/0", led, tx_data, tx_enable, cmd_overrun);
    end
    wait_cyc(e + 2 + 3 * GAP + 4);
    checks++;
    if (pulse_data.size() !== 1) begin
      failures++;
      $display("FAIL midreset_discard pulses=%0d expected 1", pulse_data.size());
    end
    clear_log();
    run_cmd(8'h01, 1, e);
    checks++;
    if (led !== 6'b000010 || pulse_data.size() !== 1 || pulse_data[0] !== 8'h81 || pulse_cyc[0] !== e + 2) begin
      failures++;
      $display("FAIL after_reset_cmd led=%b count=%0d data=%h expected 000010/1/81", led, pulse_data.size(), pulse_data[0]);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (consec_err !== 0) begin
      failures++;
      $display("FAIL tx_enable_consecutive got=%0d expected 0", consec_err);
    end
    checks++;
    if (txd_err !== 0) begin
      failures++;
      $display("FAIL tx_data_stability got=%0d expected 0", txd_err);
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_read_leds();
    test_seconds();
    test_nak_overrun();
    test_reset_mid_reply();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Command responder between `uart_rx_path` and `uart_tx_path` on the 50 MHz board clock. It decodes single-byte host commands received over the CH340 link and applies them to the 6-bit LED register. It also captures the timer seconds count on request. Every command gets a 1–3 byte reply, paced onto the UART transmitter. Replies replace the free-running seconds stream as the board's TX traffic.

## Interface
- `TX_GAP_CYCLES`, default 4800: clocks between consecutive `tx_enable` pulses. Must be at least one 10-bit byte time (4340 at 115200 baud). Minimum legal value is 2.
- `clk_50m` input 1: the only clock; everything is synchronous to its rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `rx_data` input 8: received byte from `uart_rx_path`; valid when `rx_done` rises.
- `rx_done` input 1: byte-received strobe, any width ≥1 cycle. Only its rising edge is used.
- `timer_second` input 16: seconds counter from `timer`.
- `tx_data` output 8: byte to `uart_tx_path`. Held stable from its `tx_enable` pulse until the next pulse.
- `tx_enable` output 1: one-cycle start pulse to `uart_tx_path`.
- `led` output 6: LED register.
- `cmd_overrun` output 1: one-cycle pulse when a command is dropped.

## Operation
- Reset values (clock edge with `reset_n`=0): `led`=0, `tx_data`=0x00, `tx_enable`=0, `cmd_overrun`=0, state IDLE, reply length 0.
- The `rx_done` history register resets to 1, so a strobe already high at reset release is not a command.
- Rising-edge detect: `rx_done`=1 now and 0 in the previous sample. `rx_data` is latched on that same edge.
- Command map (latched byte → action; reply bytes in send order):
  - 0x00–0x05: toggle `led[n]`; reply 0x80|n.
  - 0x10: read LEDs; reply 0x90, {2'b00, led}. The LED value is taken after this command, which is unchanged.
  - 0x11: read seconds; reply 0x91, sec[15:8], sec[7:0]. `timer_second` is sampled once, in DECODE.
  - 0x20: clear all LEDs; reply 0xA0.
  - Any other byte: no action; reply 0xEE, the offending byte (NAK).
- FSM states:
  - IDLE: a detected edge latches the byte and moves to DECODE.
  - DECODE, 1 cycle: applies the LED action, loads the 3-byte reply buffer and length (1–3), sets byte index 0, moves to SEND.
  - SEND, 1 cycle: drives `tx_data`=buffer[index] and `tx_enable`=1, loads the gap counter, moves to GAP.
  - GAP: counts down. At terminal count it goes to SEND if more bytes remain (index+1), otherwise to IDLE.
- Overrun: a rising edge detected in any state other than IDLE is dropped.
  - The dropped command has no LED effect and no reply.
  - `cmd_overrun` pulses on the next cycle.
- Reset mid-reply wins over everything: the FSM returns to IDLE, the remaining reply bytes are discarded, and `led` is cleared.
- LED writes are registered, with one write per command. `led` never changes outside DECODE or reset.

## Timing
- Let edge E be the first clock edge that samples `rx_done`=1 after a 0.
  - Edge E+1 enters DECODE.
  - Edge E+2 updates `led` and is the first edge sampling `tx_enable`=1 (SEND).
- Consecutive `tx_enable` pulses are exactly `TX_GAP_CYCLES` clocks apart.
- After the last byte, the FSM is back in IDLE `TX_GAP_CYCLES` clocks after that byte's pulse. The first cycle of IDLE accepts a new edge.
- Total busy time per command: 2 + N×`TX_GAP_CYCLES` clocks, where N is the number of reply bytes.
- `tx_enable` is never high on two consecutive clocks.
- `tx_data` changes only on edges where `tx_enable` goes high.

## Test plan
Bench uses `TX_GAP_CYCLES`=16.
- Reset release with `rx_done` held high for 10 cycles → no `tx_enable`, `led`=0, `cmd_overrun`=0.
- Send 0x03 (`rx_done` 3 cycles wide) → `led`=6'b001000 two edges after E. Exactly one `tx_enable` pulse, same edge, `tx_data`=0x83. Send 0x03 again → `led`=0, reply 0x83.
- Toggle bits 0 and 5, then send 0x10 → pulses 16 clocks apart with bytes 0x90, 0x21. Then send 0x20 → `led`=0, reply 0xA0.
- `timer_second`=0x1234 at DECODE, changing to 0x1235 during the reply, send 0x11 → bytes 0x91, 0x12, 0x34 at pulses spaced 16 clocks.
- Send 0x7F → bytes 0xEE, 0x7F; `led` unchanged. Send 0x02 between the two pulses → `cmd_overrun` pulses once, `led` unchanged, no extra reply byte.
- Send 0x11, assert `reset_n`=0 for 1 cycle after the first pulse → no further `tx_enable`, outputs at reset values. A following 0x01 → reply 0x81, `led`=6'b000010.
